// File: rtl/imm_encoder.sv
// Immediate encoder: folds an immediate into a base instruction in I/S/B/U format and queues results in a 2-entry FIFO.
// Optional range checking is compiled in with the macro IMM_RANGE_CHECK_EN; N must be at least 32.
module imm_encoder #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_imm,
    input  logic [1:0]   in_imm_sel,
    input  logic [N-1:0] in_base,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic         out_err
);

    localparam logic [1:0] SEL_I = 2'd0;
    localparam logic [1:0] SEL_S = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;
    localparam logic [1:0] SEL_U = 2'd3;

    // SLLI/SRLI/SRAI: OP-IMM opcode group with funct3 001 or 101 keeps funct7 from the base
    function automatic logic is_shift(input logic [N-1:0] base, input logic [1:0] sel);
        return (sel == SEL_I) && base[4] &&
               ((base[14:12] == 3'b001) || (base[14:12] == 3'b101));
    endfunction

    function automatic logic [N-1:0] encode_imm(input logic [N-1:0] base,
                                                input logic [N-1:0] imm,
                                                input logic [1:0]   sel);
        logic [N-1:0] instr;
        instr = base;
        case (sel)
            SEL_I: begin
                if (is_shift(base, sel)) begin
                    instr[24:20] = imm[4:0];
                end else begin
                    instr[31:20] = imm[11:0];
                end
            end
            SEL_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            SEL_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
            end
            SEL_U: begin
                instr[31:12] = imm[31:12];
            end
            default: begin
                instr = base;
            end
        endcase
        return instr;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // Upper bits must be a pure sign extension of the field the format can hold
    function automatic logic range_err(input logic [N-1:0] base,
                                       input logic [N-1:0] imm,
                                       input logic [1:0]   sel);
        logic err;
        case (sel)
            SEL_I: begin
                if (is_shift(base, sel)) begin
                    err = |imm[31:5];
                end else begin
                    err = ~((&imm[31:11]) | ~(|imm[31:11]));
                end
            end
            SEL_S: err = ~((&imm[31:11]) | ~(|imm[31:11]));
            SEL_B: err = ~((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
            SEL_U: err = |imm[11:0];
            default: err = 1'b0;
        endcase
        return err;
    endfunction
`endif

    logic [1:0]   count_r;
    logic [1:0]   count_next_s;
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic         push_s;
    logic         pop_s;
    logic [N-1:0] enc_instr_s;
    logic [N-1:0] instr_mem_r [2];
    logic         unused_imm_s;

    assign unused_imm_s = ^in_imm;
    assign in_ready     = (count_r != 2'd2);
    assign out_valid    = (count_r != 2'd0);
    assign push_s       = in_valid & in_ready;
    assign pop_s        = out_valid & out_ready;
    assign enc_instr_s  = encode_imm(in_base, in_imm, in_imm_sel);
    assign out_instr    = instr_mem_r[rd_ptr_r];

    // Occupancy update for push-only, pop-only and simultaneous transfers
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and instruction storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r        <= 2'd0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            instr_mem_r[0] <= {N{1'b0}};
            instr_mem_r[1] <= {N{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= enc_instr_s;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic err_mem_r [2];
    logic enc_err_s;

    assign enc_err_s = range_err(in_base, in_imm, in_imm_sel);
    assign out_err   = err_mem_r[rd_ptr_r];

    // Error flag storage, written alongside the instruction slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mem_r[0] <= 1'b0;
            err_mem_r[1] <= 1'b0;
        end else if (push_s) begin
            err_mem_r[wr_ptr_r] <= enc_err_s;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter N, default 32: datapath width for the immediate, base instruction and output instruction.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder can accept a request.
REQ-006 SHALL have port in_imm, input, N bits: immediate value, sign-extended two's-complement form.
REQ-007 SHALL have port in_imm_sel, input, 2 bits: immediate format; 0=I, 1=S, 2=B, 3=U.
REQ-008 SHALL have port in_base, input, N bits: instruction carrying opcode, register and funct fields; its immediate bits are ignored.
REQ-009 SHALL have port out_valid, output, 1 bit: an encoded instruction is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-011 SHALL have port out_instr, output, N bits: the encoded instruction.
REQ-012 SHALL have port out_err, output, 1 bit: the immediate was out of range for the selected format; it travels with out_instr.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, and an output on a rising edge where out_valid=1 and out_ready=1.
REQ-014 SHALL buffer results in a 2-entry FIFO: occupancy counter 0..2, 1-bit write and read pointers, and stored fields {instr, err}.
REQ-015 SHALL drive in_ready=1 exactly when occupancy<2; when occupancy=2, a simultaneous pop does not enable a push in the same cycle.
REQ-016 SHALL have a latency of 1 cycle: a request accepted at edge k into an empty FIFO gives out_valid=1 after edge k.
REQ-017 SHALL, on a simultaneous push and pop at occupancy 1, leave occupancy unchanged and present the new entry as head on the next cycle.
REQ-018 SHALL drive out_instr and out_err from the FIFO head register with no combinational path from in_* to out_*.
REQ-019 SHALL wrap both pointers modulo 2 and keep results in strict FIFO order.
REQ-020 SHALL encode I format as instr[31:20]=imm[11:0].
REQ-021 SHALL encode I-shift when sel=0, in_base[4]=1 and in_base[14:12] is 001 or 101: instr[24:20]=imm[4:0], with instr[31:25] taken from in_base.
REQ-022 SHALL encode S format as instr[31:25]=imm[11:5] and instr[11:7]=imm[4:0].
REQ-023 SHALL encode B format as instr[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5] and [11:8]=imm[4:1]; imm[0] is dropped.
REQ-024 SHALL encode U format as instr[31:12]=imm[31:12].
REQ-025 SHALL copy every bit not written by REQ-020..024 from in_base.
REQ-026 SHALL hold stored FIFO contents while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, while rst_n=0, clear occupancy and both pointers immediately, so that out_valid=0, in_ready=1, out_instr=0 and out_err=0.
REQ-028 SHALL discard any in-flight or buffered entries when reset is asserted; no partial entry survives.
REQ-029 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile range checking in only when the macro IMM_RANGE_CHECK_EN is defined.
REQ-031 SHALL, with IMM_RANGE_CHECK_EN defined, set err=1 on the following conditions:
- I or S format: imm[31:11] is not all equal.
- I-shift format: imm[31:5] is not zero.
- B format: imm[31:12] is not all equal, or imm[0]=1.
- U format: imm[11:0] is not zero.
REQ-032 SHALL, with IMM_RANGE_CHECK_EN defined, still encode truncated fields when err=1.
REQ-033 SHALL, without IMM_RANGE_CHECK_EN, tie out_err to 0 and instantiate no check logic.

Verification
REQ-034 SHALL cover: base=0x00000013, sel=0, imm=0xFFFFFFFF -> out_instr=0xFFF00013, err=0, one cycle later.
REQ-035 SHALL cover: base=0x00002023, sel=1, imm=8 -> 0x00002423; then base=0x00000063, sel=2, imm=0xFFFFFFFC -> 0xFE000EE3.
REQ-036 SHALL cover: base=0x00000037, sel=3, imm=0x12345000 -> 0x12345037; then base=0x40005013, sel=0, imm=3 -> 0x40305013.
REQ-037 SHALL cover: out_ready=0 with 3 back-to-back requests -> in_ready=0 after 2 accepts; on release, outputs drain in order with no loss.
REQ-038 SHALL cover, with IMM_RANGE_CHECK_EN defined: sel=0, imm=0x800 -> err=1; sel=2, imm=5 -> err=1; without the macro, err=0 for both.
REQ-039 SHALL cover: rst_n asserted mid-stream at occupancy 2 -> out_valid=0 immediately; after release, the first new request is output alone.
